rtc_time_counter: RTL and testbench
===================================

# rtc_time_counter

Time-of-day core for the RTC display path. Divides `sys_clk` to a 1 Hz tick and keeps a 24-hour HH:MM:SS time in packed BCD. The host can load the time directly, or step minutes and hours with single-cycle adjust pulses. Its `time_bcd` output drives the 24-bit `data` input of the six-digit seven-segment scanner directly: seconds-ones in bits 3:0, hours-tens in bits 23:20.

## Interface
- `TICK_DIV`, default 50_000_000: `sys_clk` cycles per second tick. Legal range is ≥2; benches use a small value.
- `sys_clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level. When high, the prescaler counts and time advances. When low, the prescaler holds and time freezes.
- `set_valid`  in  1  one-cycle load request.
- `set_time`  in  24  packed BCD value to load, in `time_bcd` layout; sampled when `set_valid` is high.
- `adj_min`  in  1  one-cycle pulse: add one minute.
- `adj_hour`  in  1  one-cycle pulse: add one hour.
- `time_bcd`  out  24  registered. {h10,h1,m10,m1,s10,s1}, 4 bits each.
- `sec_pulse`  out  1  registered, one cycle high on every tick-driven seconds advance.
- `set_err`  out  1  registered, one cycle high when a load is rejected.

## Operation
- **Prescaler:** `cnt` has width $clog2(TICK_DIV).
  - Increments only while `run` is high.
  - At `cnt == TICK_DIV-1`, it wraps to 0 and raises internal `tick`.
- **Counter chain:** three modulo BCD pairs.
  - Seconds 00–59, carry at 59.
  - Minutes 00–59, carry at 59.
  - Hours 00–23, wrapping 23→00.
  - Ones digits count 0–9; the tens digit increments on ones=9.
- **`tick` behaviour:** advances seconds with full carry. Example: 23:59:59 → 00:00:00. `sec_pulse` is asserted at the same edge.
- **`adj_min`:** minutes +1 modulo 60 with no carry into hours. Seconds are unchanged.
- **`adj_hour`:** hours +1 modulo 24.
- **Both adjust pulses together:** both are applied.
- **Load validation:** a load is valid when every digit is ≤9, h10 ≤2, hours ≤23, m10 ≤5 and s10 ≤5.
  - Valid load: `time_bcd` ← `set_time` and `cnt` ← 0.
  - Invalid load: time is unchanged, `cnt` keeps counting, and `set_err` pulses.
- **Priority within one cycle:** `set_valid` > `adj_*` > `tick`.
  - A valid load discards a coincident tick; the prescaler restarts.
  - An invalid load does not discard the tick.
  - A tick coincident with an adjust is held in a one-bit pending flag. It is applied on the next cycle with no higher-priority event, and `sec_pulse` fires then. At most one tick can be pending, because `TICK_DIV` ≥ 2.
- **`run` low:** load and adjust still operate. A pending tick is still applied.

## Timing
- **Reset values:** `time_bcd` = 24'h000000, `sec_pulse` = 0, `set_err` = 0, `cnt` = 0, pending = 0.
- **Reset mid-operation:** the same state is forced immediately, asynchronously.
- **First advance:** with `run` held high from reset release, `time_bcd` = 24'h000001 and `sec_pulse` = 1 after exactly `TICK_DIV` rising edges.
- **Tick rate:** subsequent ticks occur every `TICK_DIV` run-high cycles. Cycles with `run` low are not counted.
- **Load latency:** 1 cycle. `time_bcd` shows the new value in the cycle after `set_valid`, and `set_err` is asserted in that same cycle.
- **Adjust latency:** 1 cycle.
- **Output stability:** outputs change only on `sys_clk` edges. `time_bcd` is never transiently invalid BCD.

## Structure
- **Package `rtc_pkg`:**
  - Digit field offsets: S1=0, S10=4, M1=8, M10=12, H1=16, H10=20.
  - BCD limits: 4'd9, 4'd5, 4'd2, hour max 8'h23.
  - Function `rtc_time_is_valid(logic [23:0])`.
- **Sub-module `rtc_bcd_mod_counter`:**
  - Parameter: modulo, given as max BCD pair.
  - Ports: `inc`, `load`, `load_val`, `q[7:0]`, `carry`.
  - `carry` is combinational: `inc` && `q` == max.
  - Instantiated three times.
- **Top level:** contains the prescaler, the pending flag and the priority logic.

## Test plan
- **Rollover:** `TICK_DIV`=4, `run`=1, load 24'h235958 → after two ticks `time_bcd` = 24'h000000, with `sec_pulse` seen twice 4 cycles apart.
- **First tick after reset:** release reset with `run`=1 → 24'h000001 appears on edge 4. Drop `run` for 10 cycles → time frozen, no `sec_pulse`.
- **Invalid loads:** `set_time` = 24'h246000, then 24'h0A0000 → `set_err` pulses each time and time is unchanged. Load 24'h125959 → accepted, `set_err`=0.
- **Adjust wrap:** from 24'h235930, `adj_min` → 24'h230030 (no hour carry). Then `adj_hour` → 24'h000030.
- **Tick coincident with adjust:** assert `adj_min` on the tick cycle → minutes +1 at that edge, seconds +1 one cycle later with `sec_pulse`.
- **Load coincident with tick, then reset:** valid load on the tick cycle → loaded value with no seconds advance; the next tick comes `TICK_DIV` cycles later. Assert `reset_n` low mid-count → all outputs 0 immediately.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants and the load-validation helper for the RTC time-of-day core.
package rtc_pkg;

    // Bit offsets of each BCD digit inside the packed time word.
    localparam int unsigned S1  = 0;
    localparam int unsigned S10 = 4;
    localparam int unsigned M1  = 8;
    localparam int unsigned M10 = 12;
    localparam int unsigned H1  = 16;
    localparam int unsigned H10 = 20;

    // BCD limits.
    localparam logic [3:0] BcdDigitMax  = 4'd9;
    localparam logic [3:0] BcdTensMax   = 4'd5;
    localparam logic [3:0] BcdH10Max    = 4'd2;
    localparam logic [7:0] BcdHourMax   = 8'h23;
    localparam logic [7:0] BcdMinSecMax = 8'h59;

    // True when the packed word is a legal 24-hour HH:MM:SS BCD time.
    function automatic logic rtc_time_is_valid(logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i*4 +: 4] > BcdDigitMax) ok = 1'b0;
        end
        if (t[H10 +: 4] > BcdH10Max)  ok = 1'b0;
        // Digit checks above make a plain compare on the BCD pair correct.
        if (t[H1 +: 8] > BcdHourMax)  ok = 1'b0;
        if (t[M10 +: 4] > BcdTensMax) ok = 1'b0;
        if (t[S10 +: 4] > BcdTensMax) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/rtc_time_counter_if.sv
// Host-side control and status bundle of the RTC time-of-day core.
interface rtc_time_counter_if;

    logic        run;
    logic        set_valid;
    logic [23:0] set_time;
    logic        adj_min;
    logic        adj_hour;
    logic [23:0] time_bcd;
    logic        sec_pulse;
    logic        set_err;

    // Host side.
    modport master (
        output run, set_valid, set_time, adj_min, adj_hour,
        input  time_bcd, sec_pulse, set_err
    );

    // Core side.
    modport slave (
        input  run, set_valid, set_time, adj_min, adj_hour,
        output time_bcd, sec_pulse, set_err
    );

endinterface

// File: rtl/rtc_bcd_mod_counter.sv
// Two-digit BCD counter wrapping from MaxVal to 00, with synchronous load.
module rtc_bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] MaxVal = 8'h59
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       carry
);

    logic [7:0] q_d, q_q;

    // Next value: load wins over increment; ones roll into tens, pair wraps at MaxVal.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (inc) begin
            if (q_q == MaxVal) begin
                q_d = 8'h00;
            end else if (q_q[3:0] == BcdDigitMax) begin
                q_d = {q_q[7:4] + 4'd1, 4'd0};
            end else begin
                q_d = {q_q[7:4], q_q[3:0] + 4'd1};
            end
        end
    end

    // Digit pair state.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) q_q <= 8'h00;
        else          q_q <= q_d;
    end

    assign q     = q_q;
    assign carry = inc && (q_q == MaxVal);

endmodule

// File: rtl/rtc_time_counter.sv
// RTC time-of-day core: 1 Hz prescaler, HH:MM:SS BCD chain, host load and adjust.
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    rtc_time_counter_if.slave bus
);

    localparam int unsigned       CntW   = $clog2(TICK_DIV);
    localparam logic [CntW-1:0]   CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_d, cnt_q;
    logic            pend_d, pend_q;
    logic            sec_pulse_d, sec_pulse_q;
    logic            set_err_d, set_err_q;

    logic       load_ok, tick, tick_apply;
    logic       adj_min_en, adj_hour_en;
    logic       sec_carry, min_carry, hour_carry;
    logic [7:0] sec_q, min_q, hour_q;

    // Prescaler, pending-tick flag and event priority: load > adjust > tick.
    always_comb begin
        load_ok     = bus.set_valid && rtc_time_is_valid(bus.set_time);
        tick        = bus.run && (cnt_q == CntMax);
        adj_min_en  = !bus.set_valid && bus.adj_min;
        adj_hour_en = !bus.set_valid && bus.adj_hour;
        tick_apply  = 1'b0;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        if (load_ok) begin
            // Valid load restarts the second and drops any tick.
            cnt_d  = '0;
            pend_d = 1'b0;
        end else begin
            if (bus.run) cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (bus.set_valid || bus.adj_min || bus.adj_hour) begin
                pend_d = pend_q || tick;
            end else begin
                tick_apply = pend_q || tick;
                pend_d     = 1'b0;
            end
        end
        sec_pulse_d = tick_apply;
        set_err_d   = bus.set_valid && !load_ok;
    end

    // Prescaler and status flags.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            sec_pulse_q <= sec_pulse_d;
            set_err_q   <= set_err_d;
        end
    end

    rtc_bcd_mod_counter #(
        .MaxVal (BcdMinSecMax)
    ) u_sec (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .inc      (tick_apply),
        .load     (load_ok),
        .load_val (bus.set_time[S1 +: 8]),
        .q        (sec_q),
        .carry    (sec_carry)
    );

    // Adjusts never coincide with an applied tick, so adj_min cannot carry into hours.
    rtc_bcd_mod_counter #(
        .MaxVal (BcdMinSecMax)
    ) u_min (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .inc      (adj_min_en || sec_carry),
        .load     (load_ok),
        .load_val (bus.set_time[M1 +: 8]),
        .q        (min_q),
        .carry    (min_carry)
    );

    rtc_bcd_mod_counter #(
        .MaxVal (BcdHourMax)
    ) u_hour (
        .sys_clk  (sys_clk),
        .reset_n  (reset_n),
        .inc      (adj_hour_en || (sec_carry && min_carry)),
        .load     (load_ok),
        .load_val (bus.set_time[H1 +: 8]),
        .q        (hour_q),
        .carry    (hour_carry)
    );

    logic unused_hour_carry;
    assign unused_hour_carry = hour_carry;

    assign bus.time_bcd  = {hour_q, min_q, sec_q};
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter with TICK_DIV = 4.
module tb_rtc_time_counter;

    localparam int unsigned TickDiv = 4;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    rtc_time_counter_if bus ();

    rtc_time_counter #(
        .TICK_DIV (TickDiv)
    ) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Advance to the next falling edge: exactly one rising edge passes.
    task automatic step();
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.set_valid = 1'b0; bus.set_time = 24'h0;
        bus.adj_min = 1'b0; bus.adj_hour = 1'b0;
        reset_n = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (bus.time_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL reset_time: got %h want 000000", bus.time_bcd);
        end
        n_cmp++;
        if (bus.sec_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulse: got %b want 0", bus.sec_pulse);
        end
        n_cmp++;
        if (bus.set_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", bus.set_err);
        end
    endtask

    task automatic test_first_tick();
        logic [23:0] exp_t;
        logic        exp_p;
        bus.run = 1'b1;
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp_t = (i == 4) ? 24'h000001 : 24'h000000;
            exp_p = (i == 4);
            n_cmp++;
            if (bus.time_bcd !== exp_t || bus.sec_pulse !== exp_p) begin
                n_fail++;
                $display("FAIL first_tick edge %0d: got %h/%b want %h/%b",
                         i, bus.time_bcd, bus.sec_pulse, exp_t, exp_p);
            end
        end
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (bus.time_bcd !== 24'h000001 || bus.sec_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL run_low_freeze cycle %0d: got %h/%b want 000001/0",
                         i, bus.time_bcd, bus.sec_pulse);
            end
        end
        bus.run = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (bus.time_bcd !== 24'h000001 || bus.sec_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL resume_early: got %h/%b want 000001/0", bus.time_bcd, bus.sec_pulse);
        end
        step();
        n_cmp++;
        if (bus.time_bcd !== 24'h000002 || bus.sec_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_tick: got %h/%b want 000002/1", bus.time_bcd, bus.sec_pulse);
        end
    endtask

    task automatic test_rollover();
        logic [23:0] exp_t;
        logic        exp_p;
        int          pulses;
        pulses = 0;
        bus.set_valid = 1'b1; bus.set_time = 24'h235958;
        step();
        bus.set_valid = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h235958 || bus.set_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rollover_load: got %h/%b want 235958/0", bus.time_bcd, bus.set_err);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            exp_t = (i < 4) ? 24'h235958 : (i < 8) ? 24'h235959 : 24'h000000;
            exp_p = (i == 4) || (i == 8);
            if (bus.sec_pulse === 1'b1) pulses++;
            n_cmp++;
            if (bus.time_bcd !== exp_t || bus.sec_pulse !== exp_p) begin
                n_fail++;
                $display("FAIL rollover edge %0d: got %h/%b want %h/%b",
                         i, bus.time_bcd, bus.sec_pulse, exp_t, exp_p);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL rollover_pulse_count: got %0d want 2", pulses);
        end
    endtask

    task automatic test_invalid_load();
        logic [23:0] bad [2];
        bad[0] = 24'h246000;
        bad[1] = 24'h0A0000;
        bus.run = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.set_valid = 1'b1; bus.set_time = bad[k];
            step();
            bus.set_valid = 1'b0;
            n_cmp++;
            if (bus.set_err !== 1'b1 || bus.time_bcd !== 24'h000000) begin
                n_fail++;
                $display("FAIL invalid_load %h: got err %b time %h want 1/000000",
                         bad[k], bus.set_err, bus.time_bcd);
            end
            step();
            n_cmp++;
            if (bus.set_err !== 1'b0) begin
                n_fail++; $display("FAIL invalid_err_clear %h: got %b want 0", bad[k], bus.set_err);
            end
        end
        bus.set_valid = 1'b1; bus.set_time = 24'h125959;
        step();
        bus.set_valid = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h125959 || bus.set_err !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_load: got %h/%b want 125959/0", bus.time_bcd, bus.set_err);
        end
    endtask

    task automatic test_adjust_wrap();
        bus.set_valid = 1'b1; bus.set_time = 24'h235930;
        step();
        bus.set_valid = 1'b0;
        bus.adj_min = 1'b1;
        step();
        bus.adj_min = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h230030) begin
            n_fail++; $display("FAIL adj_min_wrap: got %h want 230030", bus.time_bcd);
        end
        bus.adj_hour = 1'b1;
        step();
        bus.adj_hour = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h000030) begin
            n_fail++; $display("FAIL adj_hour_wrap: got %h want 000030", bus.time_bcd);
        end
        bus.adj_min = 1'b1; bus.adj_hour = 1'b1;
        step();
        bus.adj_min = 1'b0; bus.adj_hour = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h010130 || bus.sec_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL adj_both: got %h/%b want 010130/0", bus.time_bcd, bus.sec_pulse);
        end
    endtask

    task automatic test_tick_adjust();
        bus.run = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (bus.time_bcd !== 24'h010130 || bus.sec_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_tick: got %h/%b want 010130/0", bus.time_bcd, bus.sec_pulse);
        end
        bus.adj_min = 1'b1;
        step();
        bus.adj_min = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h010230 || bus.sec_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_adj_edge: got %h/%b want 010230/0", bus.time_bcd, bus.sec_pulse);
        end
        step();
        n_cmp++;
        if (bus.time_bcd !== 24'h010231 || bus.sec_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_apply: got %h/%b want 010231/1", bus.time_bcd, bus.sec_pulse);
        end
        repeat (2) step();
        n_cmp++;
        if (bus.time_bcd !== 24'h010231 || bus.sec_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL post_pending: got %h/%b want 010231/0", bus.time_bcd, bus.sec_pulse);
        end
        step();
        n_cmp++;
        if (bus.time_bcd !== 24'h010232 || bus.sec_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL next_tick: got %h/%b want 010232/1", bus.time_bcd, bus.sec_pulse);
        end
    endtask

    task automatic test_load_tick_reset();
        repeat (3) step();
        bus.set_valid = 1'b1; bus.set_time = 24'h080000;
        step();
        bus.set_valid = 1'b0;
        n_cmp++;
        if (bus.time_bcd !== 24'h080000 || bus.sec_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL load_on_tick: got %h/%b want 080000/0", bus.time_bcd, bus.sec_pulse);
        end
        repeat (3) step();
        n_cmp++;
        if (bus.time_bcd !== 24'h080000 || bus.sec_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_early: got %h/%b want 080000/0", bus.time_bcd, bus.sec_pulse);
        end
        step();
        n_cmp++;
        if (bus.time_bcd !== 24'h080001 || bus.sec_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_tick: got %h/%b want 080001/1", bus.time_bcd, bus.sec_pulse);
        end
        bus.set_valid = 1'b1; bus.set_time = 24'hFFFFFF;
        step();
        bus.set_valid = 1'b0;
        n_cmp++;
        if (bus.set_err !== 1'b1 || bus.time_bcd !== 24'h080001) begin
            n_fail++;
            $display("FAIL err_before_reset: got %b/%h want 1/080001", bus.set_err, bus.time_bcd);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.time_bcd !== 24'h000000 || bus.sec_pulse !== 1'b0 || bus.set_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%b/%b want 000000/0/0",
                     bus.time_bcd, bus.sec_pulse, bus.set_err);
        end
        step();
        reset_n = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (bus.time_bcd !== 24'h000000) begin
            n_fail++; $display("FAIL post_reset_early: got %h want 000000", bus.time_bcd);
        end
        step();
        n_cmp++;
        if (bus.time_bcd !== 24'h000001 || bus.sec_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_tick: got %h/%b want 000001/1", bus.time_bcd, bus.sec_pulse);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_rollover();
        test_invalid_load();
        test_adjust_wrap();
        test_tick_adjust();
        test_load_tick_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
